// File: rtl/lsu_unit.sv
// Load/store unit: runs one request/grant/response transaction on a word-addressed
// data bus per pipeline request, returning an extended load result or an error flag.
module lsu_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        mem_wren_i,
    input  logic [2:0]  loadsave_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] LAST   = LAST_INT[CW-1:0];

    state_e        state_q;
    logic [2:0]    op_q;
    logic [1:0]    lane_q;
    logic          we_q;
    logic          err_q;
    logic [31:0]   ld_data_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic [CW-1:0] cnt_q;

    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic          misaligned_d;
    logic          illegal_d;
    logic          timeout_hit;
    logic [31:0]   ld_ext;

    // Decode of the incoming request; only consumed when accepted in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        be_d         = 4'b1111;
        wdata_d      = st_data_i;
        misaligned_d = 1'b0;
        illegal_d    = (loadsave_op_i == 3'b011) || (loadsave_op_i[2:1] == 2'b11);
        case (loadsave_op_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr_i[1:0];
                wdata_d = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                be_d         = 4'b0011 << addr_i[1:0];
                wdata_d      = {2{st_data_i[15:0]}};
                misaligned_d = addr_i[0];
            end
            default: begin
                misaligned_d = (addr_i[1:0] != 2'b00);
            end
        endcase
    end

    function automatic logic [31:0] load_ext(input logic [2:0]  op,
                                             input logic [1:0]  lane,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (op)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    assign ld_ext      = load_ext(op_q, lane_q, mem_rdata_i);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= 3'b000;
            lane_q      <= 2'b00;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            ld_data_q   <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'b0000;
            cnt_q       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        op_q   <= loadsave_op_i;
                        lane_q <= addr_i[1:0];
                        we_q   <= mem_wren_i;
                        cnt_q  <= '0;
                        if (illegal_d || misaligned_d) begin
                            err_q     <= 1'b1;
                            ld_data_q <= 32'd0;
                            state_q   <= DONE;
                        end else begin
                            err_q       <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= mem_wren_i;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_be_q    <= be_d;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (we_q) begin
                            ld_data_q <= 32'd0;
                            state_q   <= DONE;
                        end else if (mem_rvalid_i) begin
                            ld_data_q <= ld_ext;
                            state_q   <= DONE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= 1'b1;
                        ld_data_q <= 32'd0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        ld_data_q <= ld_ext;
                        state_q   <= DONE;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        ld_data_q <= 32'd0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    err_q     <= 1'b0;
                    ld_data_q <= 32'd0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ld_data_o   = ld_data_q;
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign busy_o      = (state_q != IDLE);
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed test-plan cases plus randomized
// transactions checked cycle by cycle against a transaction-level reference model.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wren = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] st = 32'd0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;

    logic [31:0] ld_a, ld_t, maddr_a, maddr_t, wd_a, wd_t;
    logic        done_a, done_t, err_a, err_t, busy_a, busy_t;
    logic        mreq_a, mreq_t, mwe_a, mwe_t;
    logic [3:0]  be_a, be_t;

    bit          sel_t = 1'b0;
    logic [31:0] o_ld, o_maddr, o_wd;
    logic        o_done, o_err, o_busy, o_req, o_we;
    logic [3:0]  o_be;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] last_ld, last_be, last_wd, last_addr;

    always #5 clk = ~clk;

    lsu_unit dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .mem_wren_i(wren), .loadsave_op_i(op),
        .addr_i(addr), .st_data_i(st), .ld_data_o(ld_a), .done_o(done_a), .err_o(err_a),
        .busy_o(busy_a), .mem_req_o(mreq_a), .mem_we_o(mwe_a), .mem_addr_o(maddr_a),
        .mem_wdata_o(wd_a), .mem_be_o(be_a), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
        .mem_rdata_i(rdata)
    );

    lsu_unit #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk_i(clk), .rst_i(rst), .req_i(req), .mem_wren_i(wren), .loadsave_op_i(op),
        .addr_i(addr), .st_data_i(st), .ld_data_o(ld_t), .done_o(done_t), .err_o(err_t),
        .busy_o(busy_t), .mem_req_o(mreq_t), .mem_we_o(mwe_t), .mem_addr_o(maddr_t),
        .mem_wdata_o(wd_t), .mem_be_o(be_t), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
        .mem_rdata_i(rdata)
    );

    assign o_ld    = sel_t ? ld_t    : ld_a;
    assign o_done  = sel_t ? done_t  : done_a;
    assign o_err   = sel_t ? err_t   : err_a;
    assign o_busy  = sel_t ? busy_t  : busy_a;
    assign o_req   = sel_t ? mreq_t  : mreq_a;
    assign o_we    = sel_t ? mwe_t   : mwe_a;
    assign o_maddr = sel_t ? maddr_t : maddr_a;
    assign o_wd    = sel_t ? wd_t    : wd_a;
    assign o_be    = sel_t ? be_t    : be_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference load extraction: pick the addressed lane arithmetically, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a, input logic [31:0] word);
        logic [31:0] lane;
        int          v;
        lane = word >> (8 * a);
        case (f3)
            3'd0, 3'd4: begin
                v = int'(lane & 32'hFF);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
                return 32'(v);
            end
            3'd1, 3'd5: begin
                v = int'(lane & 32'hFFFF);
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
                return 32'(v);
            end
            default: return word;
        endcase
    endfunction

    // One full transaction from an IDLE observation point to the next IDLE cycle.
    // g: REQ cycles without grant before the grant; r: cycles from grant to rvalid (0 = same cycle).
    task automatic run_txn(input string name, input logic [2:0] f3, input logic w,
                           input logic [31:0] ad, input logic [31:0] sd,
                           input int g, input int r, input logic [31:0] word);
        int          t_lim, a, sz, gnt_c, done_c, req_last;
        bit          bad, exp_err;
        logic [31:0] exp_ld, exp_be, exp_wd;
        t_lim = sel_t ? 4 : 16;
        a     = int'(ad[1:0]);
        sz    = int'(f3[1:0]);
        bad   = (f3 == 3'd3) || (f3 >= 3'd6) || (sz == 1 && (a % 2) != 0) || (sz == 2 && a != 0);
        gnt_c = 1 + g;
        if (bad) begin
            done_c = 1; exp_err = 1'b1; req_last = 0;
        end else if (g >= t_lim) begin
            done_c = t_lim + 1; exp_err = 1'b1; req_last = t_lim;
        end else begin
            req_last = gnt_c;
            if (w || r == 0) begin
                done_c = gnt_c + 1; exp_err = 1'b0;
            end else if (r > t_lim) begin
                done_c = gnt_c + t_lim + 1; exp_err = 1'b1;
            end else begin
                done_c = gnt_c + r + 1; exp_err = 1'b0;
            end
        end
        exp_ld = (exp_err || w) ? 32'd0 : ref_load(f3, a, word);
        case (sz)
            0:       begin exp_be = 32'(1 << a); exp_wd = (sd & 32'hFF) * 32'h01010101; end
            1:       begin exp_be = 32'(3 << a); exp_wd = (sd & 32'hFFFF) * 32'h00010001; end
            default: begin exp_be = 32'd15;      exp_wd = sd; end
        endcase

        check({name, ".idle_done"}, o_done, 0);
        check({name, ".idle_busy"}, o_busy, 0);
        req = 1'b1; wren = w; op = f3; addr = ad; st = sd;
        gnt = 1'b0; rvalid = 1'($urandom_range(0, 1)); rdata = $urandom;

        for (int c = 1; c <= done_c + 1; c++) begin
            step();
            check({name, ".done"}, o_done, 32'(c == done_c));
            check({name, ".busy"}, o_busy, 32'(c >= 1 && c <= done_c));
            check({name, ".mem_req"}, o_req, 32'(c >= 1 && c <= req_last));
            check({name, ".ld_data"}, o_ld, (c == done_c) ? exp_ld : 32'd0);
            if (c == done_c) begin
                check({name, ".err"}, o_err, 32'(exp_err));
                last_ld = o_ld;
            end
            if (c <= req_last) begin
                check({name, ".mem_addr"}, o_maddr, {ad[31:2], 2'b00});
                check({name, ".mem_be"}, 32'(o_be), exp_be);
                check({name, ".mem_wdata"}, o_wd, exp_wd);
                check({name, ".mem_we"}, o_we, 32'(w));
                if (c == 1) begin
                    last_be = 32'(o_be); last_wd = o_wd; last_addr = o_maddr;
                end
            end
            req = 1'b0;
            gnt = (c == gnt_c) && !bad;
            if (!bad && !w && c == gnt_c + r) begin
                rvalid = 1'b1; rdata = word;
            end else if (c < gnt_c) begin
                rvalid = 1'($urandom_range(0, 1)); rdata = $urandom;
            end else begin
                rvalid = 1'b0; rdata = $urandom;
            end
        end
    endtask

    task automatic quiet();
        req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] ad;
        int          g, r;

        do_reset();
        check("rst.done", o_done, 0);
        check("rst.err", o_err, 0);
        check("rst.busy", o_busy, 0);
        check("rst.mem_req", o_req, 0);
        check("rst.mem_we", o_we, 0);
        check("rst.ld_data", o_ld, 0);
        check("rst.mem_addr", o_maddr, 0);
        check("rst.mem_wdata", o_wd, 0);
        check("rst.mem_be", 32'(o_be), 0);

        run_txn("sb", 3'd0, 1'b1, 32'h1003, 32'h000000AB, 0, 0, 32'd0);
        check("sb.addr_c1", last_addr, 32'h1000);
        check("sb.be_c1", last_be, 32'h8);
        check("sb.wdata_c1", last_wd, 32'hABABABAB);

        run_txn("lb", 3'd0, 1'b0, 32'h2001, 32'd0, 0, 1, 32'h8081F0F1);
        check("lb.value", last_ld, 32'hFFFFFFF0);
        run_txn("lbu", 3'd4, 1'b0, 32'h2001, 32'd0, 0, 1, 32'h8081F0F1);
        check("lbu.value", last_ld, 32'h000000F0);
        run_txn("lh", 3'd1, 1'b0, 32'h2002, 32'd0, 0, 1, 32'h8081F0F1);
        check("lh.value", last_ld, 32'hFFFF8081);
        run_txn("lhu", 3'd5, 1'b0, 32'h2002, 32'd0, 0, 1, 32'h8081F0F1);
        check("lhu.value", last_ld, 32'h00008081);
        run_txn("lw", 3'd2, 1'b0, 32'h2000, 32'd0, 0, 1, 32'h8081F0F1);
        check("lw.value", last_ld, 32'h8081F0F1);
        run_txn("lw_same", 3'd2, 1'b0, 32'h2004, 32'd0, 0, 0, 32'h12345678);

        run_txn("lw_mis", 3'd2, 1'b0, 32'h3002, 32'd0, 0, 0, 32'hFFFFFFFF);
        run_txn("sh_mis", 3'd1, 1'b1, 32'h3001, 32'h1234, 0, 0, 32'd0);
        run_txn("illegal", 3'd3, 1'b0, 32'h3000, 32'd0, 0, 0, 32'hFFFFFFFF);
        run_txn("stall", 3'd2, 1'b1, 32'h3100, 32'hCAFEF00D, 3, 0, 32'd0);

        for (int i = 0; i < 250; i++) begin
            f3 = 3'($urandom_range(0, 7));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0)
                ad[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : (f3[1:0] == 2'b01) ? (ad[1:0] & 2'b10) : ad[1:0];
            g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(0, 3));
            r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
            run_txn("rnd", f3, 1'($urandom_range(0, 1)), ad, $urandom, g, r, $urandom);
        end

        // Reset while waiting for read data.
        req = 1'b1; wren = 1'b0; op = 3'd2; addr = 32'h5000; gnt = 1'b0; rvalid = 1'b0;
        step();
        req = 1'b0; gnt = 1'b1;
        step();
        check("rstmid.wait_req", o_req, 0);
        check("rstmid.wait_busy", o_busy, 1);
        gnt = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid.busy", o_busy, 0);
        check("rstmid.mem_req", o_req, 0);
        check("rstmid.done", o_done, 0);
        step();
        check("rstmid.done2", o_done, 0);
        run_txn("sw_after", 3'd2, 1'b1, 32'h4000, 32'h55AA33CC, 0, 0, 32'd0);
        check("sw_after.be", last_be, 32'hF);

        // Request held high: one access accepted per IDLE cycle, period of three.
        req = 1'b1; wren = 1'b1; op = 3'd2; addr = 32'h6000; st = 32'h1; gnt = 1'b1; rvalid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            check("hold.done", o_done, 32'(c % 3 == 2));
            check("hold.mem_req", o_req, 32'(c % 3 == 1));
            step();
        end
        quiet();
        step();
        step();

        // Short-timeout instance.
        do_reset();
        sel_t = 1'b1;
        run_txn("tmo_wait", 3'd2, 1'b0, 32'h2000, 32'd0, 0, 100, 32'hDEADBEEF);
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        step();
        rvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("tmo_late.done", o_done, 0);
            check("tmo_late.busy", o_busy, 0);
            step();
        end
        run_txn("tmo_req", 3'd0, 1'b1, 32'h7001, 32'h77, 5, 0, 32'd0);
        run_txn("tmo_edge_g", 3'd2, 1'b1, 32'h7004, 32'h9, 3, 0, 32'd0);
        run_txn("tmo_edge_r", 3'd1, 1'b0, 32'h7002, 32'd0, 0, 4, 32'hF00D8000);
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            ad = $urandom;
            ad[1:0] = (f3[1:0] == 2'b00) ? ad[1:0] : 2'b00;
            run_txn("rnd_t", f3, 1'($urandom_range(0, 1)), ad, $urandom,
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), $urandom);
        end
        quiet();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit between the execute stage and the data-memory bus. Consumes the `mem_wren` and `loadsave_op` controls from the control unit, plus the ALU-computed address and the rs2 store data. Runs a request/grant/response transaction on a 32-bit word-addressed memory bus with byte enables. Returns a sign- or zero-extended load result with a one-cycle `done_o` pulse, and flags misaligned, illegal or timed-out accesses.

## Interface
- `TIMEOUT_CYCLES`, default 16: max cycles spent in REQ or WAIT before abort; 0 disables the timeout.
- `clk_i` in 1: clock; everything is clocked on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in 1: pipeline requests an access; sampled only in IDLE.
- `mem_wren_i` in 1: 1 = store, 0 = load.
- `loadsave_op_i` in 3: funct3 encoding.
  - 000 = LB/SB, 001 = LH/SH, 010 = LW/SW, 100 = LBU, 101 = LHU.
  - 011, 110 and 111 are illegal.
- `addr_i` in 32: byte address from the ALU.
- `st_data_i` in 32: store data, LSB-aligned.
- `ld_data_o` out 32: extended load result; valid while `done_o` = 1, otherwise 0.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: asserted together with `done_o` when the access aborted.
- `busy_o` out 1: state is not IDLE.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: bus write.
- `mem_addr_o` out 32: word-aligned address, {addr[31:2], 2'b00}.
- `mem_wdata_o` out 32: lane-replicated store data.
- `mem_be_o` out 4: byte enables.
- `mem_gnt_i` in 1: bus accepts the request this cycle.
- `mem_rvalid_i` in 1: read data is valid this cycle.
- `mem_rdata_i` in 32: read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. All outputs come from registers or decode the current state; none depend combinationally on `req_i`.
- IDLE, on `req_i` = 1:
  - Latch op, we, addr and st_data.
  - Misaligned access (half with addr[0] = 1, word with addr[1:0] ≠ 0) or illegal op: go to DONE with the error flag set. No bus cycle is issued.
  - Otherwise go to REQ.
- REQ: `mem_req_o` = 1; `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are held stable until grant.
  - `mem_gnt_i` with a store: go to DONE.
  - `mem_gnt_i` with a load and `mem_rvalid_i` in the same cycle: capture the data, go to DONE.
  - `mem_gnt_i` with a load otherwise: go to WAIT.
- WAIT: `mem_req_o` = 0. On `mem_rvalid_i`, capture the extended `mem_rdata_i` and go to DONE. `mem_rvalid_i` seen in IDLE, REQ-without-gnt or DONE is ignored.
- DONE: `done_o` = 1 for exactly one cycle, `err_o` per the flag, then IDLE. `req_i` is not accepted in DONE; the earliest next acceptance is the following IDLE cycle.
- Byte enables, with a = addr[1:0]:
  - byte: 4'b0001 << a
  - half: 4'b0011 << a
  - word: 4'b1111
  - Loads drive the same enables.
- Store data:
  - byte: {4{st[7:0]}}
  - half: {2{st[15:0]}}
  - word: st
- Load extraction: lane = rdata >> (8*a).
  - LB: sign-extend lane[7:0]. LBU: zero-extend lane[7:0].
  - LH: sign-extend lane[15:0]. LHU: zero-extend lane[15:0].
  - LW: rdata unchanged.
- Timeout:
  - A counter clears on entry to REQ and on entry to WAIT, and increments each cycle spent in those states.
  - When it reaches `TIMEOUT_CYCLES` (≠ 0): go to DONE with `err_o` = 1 and `ld_data_o` = 0, and drop `mem_req_o`.
  - A late `mem_rvalid_i` arriving after the abort is ignored.
- On any error, `ld_data_o` = 0.

## Timing
- Reset: state = IDLE; `done_o`, `err_o`, `busy_o`, `mem_req_o` and `mem_we_o` are 0; `ld_data_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are 0; timeout counter is 0.
- Reset asserted mid-transaction: the next cycle is IDLE with `mem_req_o` = 0. No `done_o` is produced for the aborted access.
- Cycle numbering takes `req_i` sampled in IDLE as cycle 0.
  - Store, grant in cycle 1: `done_o` in cycle 2.
  - Load, gnt in cycle 1, rvalid in cycle 2: `done_o` in cycle 3.
  - Load, gnt and rvalid both in cycle 1: `done_o` in cycle 2.
  - Misaligned or illegal access: `done_o` and `err_o` in cycle 1, with `mem_req_o` never asserted.
- `busy_o` rises in cycle 1 and falls in the cycle after `done_o`.
- Timeout, `TIMEOUT_CYCLES` = N, gnt never asserted: REQ is held for N cycles (cycles 1..N); `done_o` and `err_o` in cycle N+1.

## Test plan
- SB, addr = 0x1003, st = 0x000000AB, gnt in cycle 1:
  - Cycle 1 drives `mem_addr_o` = 0x1000, `mem_be_o` = 1000, `mem_wdata_o` = 0xABABABAB, `mem_we_o` = 1.
  - `done_o` in cycle 2, `err_o` = 0.
- Load extension, gnt in cycle 1, rdata = 0x8081F0F1, rvalid in cycle 2:
  - LB addr = 0x2001 → `ld_data_o` = 0xFFFFFFF0.
  - LBU addr = 0x2001 → 0x000000F0.
  - LH addr = 0x2002 → 0xFFFF8081.
  - LHU addr = 0x2002 → 0x00008081.
  - LW addr = 0x2000 → 0x8081F0F1.
  - Each returns `done_o` in cycle 3.
- Misaligned and illegal accesses:
  - LW addr = 0x3002 → `done_o` = `err_o` = 1 in cycle 1, `mem_req_o` stays 0, `ld_data_o` = 0.
  - SH addr = 0x3001 → same response.
  - op = 011 → same response.
- Grant stall: gnt held low for 3 cycles with `TIMEOUT_CYCLES` = 16:
  - `mem_req_o`, address, enables and data stay stable for 4 cycles.
  - Grant on the 4th REQ cycle completes normally.
- Timeout: `TIMEOUT_CYCLES` = 4, load with gnt in cycle 1 and rvalid never asserted:
  - `done_o` and `err_o` in cycle 6, `ld_data_o` = 0.
  - A later rvalid pulse produces no `done_o`.
- Reset and back-to-back requests:
  - `rst_i` asserted in WAIT → IDLE next cycle, no `done_o`. A new SW to addr 0x4000 then completes with `mem_be_o` = 1111.
  - `req_i` held high continuously → accepted only in IDLE cycles, giving one access per completion.
